fifo_rr_scheduler: RTL and testbench

Round-robin pop scheduler that drains several 6-bit FIFOs into one output stream. It asserts at most one FIFO `pop` per cycle, selecting channels in rotation and skipping empty ones. It stalls while the downstream `Pausa` back-pressure is high and halts permanently on any FIFO error. It sits between the per-channel FIFO bank and the downstream FIFO/consumer.

---
 rtl/fifo_sched_pkg.sv | 13 +
 rtl/fifo_rr_scheduler_rr_pick.sv | 30 +++
 rtl/fifo_rr_scheduler.sv | 95 +++++++++
 tb/tb_fifo_rr_scheduler.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_sched_pkg.sv
// rtl/fifo_sched_pkg.sv - shared state encoding and defaults for the round-robin FIFO scheduler
package fifo_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    ERROR = 2'b10
  } state_t;

  localparam int NUM_CH_DEF = 4;
  localparam int DATA_W_DEF = 6;

endpackage

// File: rtl/fifo_rr_scheduler_rr_pick.sv
// rtl/fifo_rr_scheduler_rr_pick.sv - combinational round-robin picker
// Rotates requests so the pointer sits at bit 0, finds the lowest set bit, rotates the index back.
module rr_pick #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx,
  output logic              any_grant
);

  logic [NUM_CH-1:0] req_rot;
  logic [CH_W-1:0]   first_rot;

  always_comb begin
    req_rot   = NUM_CH'({req, req} >> ptr);
    first_rot = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req_rot[i]) first_rot = CH_W'(i);
    end
    any_grant = |req;
    // NUM_CH is a power of two, so the CH_W-bit add wraps modulo NUM_CH
    grant_idx = first_rot + ptr;
    grant     = '0;
    if (any_grant) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// rtl/fifo_rr_scheduler.sv - round-robin pop scheduler draining NUM_CH FIFOs into one stream
module fifo_rr_scheduler
  import fifo_sched_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset_L,
  input  logic                     enable,
  input  logic [NUM_CH-1:0]        Fifo_Empty,
  input  logic [NUM_CH-1:0]        Fifo_Error,
  input  logic [NUM_CH*DATA_W-1:0] Fifo_Data_out,
  input  logic                     Pausa,
  output logic [NUM_CH-1:0]        pop,
  output logic [DATA_W-1:0]        data_out,
  output logic                     valid_out,
  output logic [CH_W-1:0]          ch_out,
  output logic                     error_out
);

  state_t              state_q, state_d;
  logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                pend_q, pend_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CH_W-1:0]     ch_out_q, ch_out_d;
  logic                error_q, error_d;
  logic [NUM_CH-1:0]   grant;
  logic [CH_W-1:0]     grant_idx;
  logic                any_grant;
  logic                pop_fire;

  rr_pick #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_rr_pick (
    .req       (~Fifo_Empty),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  always_comb begin
    pop_fire = (state_q == RUN) && !Pausa && any_grant;
    pop      = pop_fire ? grant : '0;

    state_d = state_q;
    if (state_q != ERROR && |Fifo_Error) begin
      state_d = ERROR;
    end else if (state_q == IDLE && enable) begin
      state_d = RUN;
    end else if (state_q == RUN && !enable) begin
      state_d = IDLE;
    end
    error_d = (state_d == ERROR);

    rr_ptr_d = pop_fire ? grant_idx + CH_W'(1) : rr_ptr_q;
    pend_d   = pop_fire;
    ch_d     = pop_fire ? grant_idx : ch_q;

    // FIFO data appears the cycle after its pop, so stage 2 reads it under pend_q
    valid_d  = pend_q;
    data_d   = pend_q ? Fifo_Data_out[ch_q*DATA_W +: DATA_W] : data_q;
    ch_out_d = pend_q ? ch_q : ch_out_q;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q  <= IDLE;
      error_q  <= 1'b0;
      rr_ptr_q <= '0;
      pend_q   <= 1'b0;
      ch_q     <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      ch_out_q <= '0;
    end else begin
      state_q  <= state_d;
      error_q  <= error_d;
      rr_ptr_q <= rr_ptr_d;
      pend_q   <= pend_d;
      ch_q     <= ch_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      ch_out_q <= ch_out_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign ch_out    = ch_out_q;
  assign error_out = error_q;

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// tb/tb_fifo_rr_scheduler.sv - directed self-checking bench for fifo_rr_scheduler
module tb_fifo_rr_scheduler;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 6;
  localparam int CH_W   = 2;

  logic                     clk = 1'b0;
  logic                     reset_L;
  logic                     enable;
  logic [NUM_CH-1:0]        Fifo_Empty;
  logic [NUM_CH-1:0]        Fifo_Error;
  logic [NUM_CH*DATA_W-1:0] Fifo_Data_out;
  logic                     Pausa;
  logic [NUM_CH-1:0]        pop;
  logic [DATA_W-1:0]        data_out;
  logic                     valid_out;
  logic [CH_W-1:0]          ch_out;
  logic                     error_out;

  logic [DATA_W-1:0] q [NUM_CH][$];
  logic [DATA_W-1:0] fd [NUM_CH];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fifo_rr_scheduler #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CH_W(CH_W)) dut (
    .clk           (clk),
    .reset_L       (reset_L),
    .enable        (enable),
    .Fifo_Empty    (Fifo_Empty),
    .Fifo_Error    (Fifo_Error),
    .Fifo_Data_out (Fifo_Data_out),
    .Pausa         (Pausa),
    .pop           (pop),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .ch_out        (ch_out),
    .error_out     (error_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < NUM_CH; i++) begin
      Fifo_Empty[i] = (q[i].size() == 0);
      Fifo_Data_out[i*DATA_W +: DATA_W] = fd[i];
    end
  endtask

  // FIFO bank model: a pop seen before the edge presents the head word just after it
  task automatic tick();
    logic [NUM_CH-1:0] p;
    p = pop;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (p[i] && q[i].size() > 0) fd[i] = q[i].pop_front();
    end
    refresh();
    @(negedge clk);
  endtask

  task automatic expect_cyc(input string tag, input logic [NUM_CH-1:0] ep, input logic ev,
                            input logic [DATA_W-1:0] ed, input logic [CH_W-1:0] ec);
    #1;
    check({tag, ".pop"}, 32'(pop), 32'(ep));
    check({tag, ".valid"}, 32'(valid_out), 32'(ev));
    if (ev) begin
      check({tag, ".data"}, 32'(data_out), 32'(ed));
      check({tag, ".ch"}, 32'(ch_out), 32'(ec));
    end
    tick();
  endtask

  task automatic do_reset();
    reset_L    = 1'b0;
    enable     = 1'b0;
    Pausa      = 1'b0;
    Fifo_Error = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      q[i].delete();
      fd[i] = '0;
    end
    refresh();
    @(negedge clk);
    @(negedge clk);
    reset_L = 1'b1;
    @(negedge clk);
  endtask

  task automatic load(input int ch, input logic [DATA_W-1:0] w);
    q[ch].push_back(w);
    refresh();
  endtask

  // channel i holds words i+1 then i+5
  task automatic load_all2();
    for (int i = 0; i < NUM_CH; i++) begin
      q[i].push_back(DATA_W'(i + 1));
      q[i].push_back(DATA_W'(i + 5));
    end
    refresh();
  endtask

  initial begin
    reset_L = 1'b1; enable = 1'b0; Pausa = 1'b0; Fifo_Error = '0;
    Fifo_Empty = '1; Fifo_Data_out = '0;
    for (int i = 0; i < NUM_CH; i++) fd[i] = '0;
    #2;
    reset_L = 1'b0;
    for (int k = 0; k < 3; k++) begin
      enable        = 1'($urandom);
      Pausa         = 1'($urandom);
      Fifo_Empty    = NUM_CH'($urandom);
      Fifo_Error    = NUM_CH'($urandom);
      Fifo_Data_out = (NUM_CH*DATA_W)'($urandom);
      #1;
      check("rst.pop", 32'(pop), 32'h0);
      check("rst.data", 32'(data_out), 32'h0);
      check("rst.valid", 32'(valid_out), 32'h0);
      check("rst.ch", 32'(ch_out), 32'h0);
      check("rst.err", 32'(error_out), 32'h0);
      @(negedge clk);
    end
    Fifo_Error = '0;
    enable     = 1'b0;
    Pausa      = 1'b0;
    for (int i = 0; i < NUM_CH; i++) q[i].delete();
    refresh();
    load(0, 6'h2A);
    reset_L = 1'b1;
    for (int k = 0; k < 3; k++) expect_cyc("dis", 4'b0000, 1'b0, 6'h0, 2'd0);

    do_reset();
    load(2, 6'h11);
    load(2, 6'h16);
    enable = 1'b1;
    expect_cyc("one.A", 4'b0000, 1'b0, 6'h00, 2'd0);
    expect_cyc("one.B", 4'b0100, 1'b0, 6'h00, 2'd0);
    expect_cyc("one.C", 4'b0100, 1'b0, 6'h00, 2'd0);
    expect_cyc("one.D", 4'b0000, 1'b1, 6'h11, 2'd2);
    expect_cyc("one.E", 4'b0000, 1'b1, 6'h16, 2'd2);
    expect_cyc("one.F", 4'b0000, 1'b0, 6'h00, 2'd0);
    check("one.hold_data", 32'(data_out), 32'h16);
    check("one.hold_ch", 32'(ch_out), 32'd2);

    do_reset();
    load_all2();
    enable = 1'b1;
    expect_cyc("rot.A", 4'b0000, 1'b0, 6'h00, 2'd0);
    expect_cyc("rot.B", 4'b0001, 1'b0, 6'h00, 2'd0);
    expect_cyc("rot.C", 4'b0010, 1'b0, 6'h00, 2'd0);
    expect_cyc("rot.D", 4'b0100, 1'b1, 6'h01, 2'd0);
    expect_cyc("rot.E", 4'b1000, 1'b1, 6'h02, 2'd1);
    expect_cyc("rot.F", 4'b0001, 1'b1, 6'h03, 2'd2);
    expect_cyc("rot.G", 4'b0010, 1'b1, 6'h04, 2'd3);
    expect_cyc("rot.H", 4'b0100, 1'b1, 6'h05, 2'd0);
    expect_cyc("rot.I", 4'b1000, 1'b1, 6'h06, 2'd1);
    expect_cyc("rot.J", 4'b0000, 1'b1, 6'h07, 2'd2);
    expect_cyc("rot.K", 4'b0000, 1'b1, 6'h08, 2'd3);
    expect_cyc("rot.L", 4'b0000, 1'b0, 6'h00, 2'd0);

    do_reset();
    load(0, 6'h01); load(0, 6'h05); load(2, 6'h03); load(3, 6'h04);
    enable = 1'b1;
    expect_cyc("skip.A", 4'b0000, 1'b0, 6'h00, 2'd0);
    expect_cyc("skip.B", 4'b0001, 1'b0, 6'h00, 2'd0);
    expect_cyc("skip.C", 4'b0100, 1'b0, 6'h00, 2'd0);
    expect_cyc("skip.D", 4'b1000, 1'b1, 6'h01, 2'd0);
    expect_cyc("skip.E", 4'b0001, 1'b1, 6'h03, 2'd2);
    expect_cyc("skip.F", 4'b0000, 1'b1, 6'h04, 2'd3);
    expect_cyc("skip.G", 4'b0000, 1'b1, 6'h05, 2'd0);
    expect_cyc("skip.H", 4'b0000, 1'b0, 6'h00, 2'd0);

    do_reset();
    load_all2();
    enable = 1'b1;
    expect_cyc("bp.A", 4'b0000, 1'b0, 6'h00, 2'd0);
    expect_cyc("bp.B", 4'b0001, 1'b0, 6'h00, 2'd0);
    expect_cyc("bp.C", 4'b0010, 1'b0, 6'h00, 2'd0);
    Pausa = 1'b1;
    expect_cyc("bp.D", 4'b0000, 1'b1, 6'h01, 2'd0);
    expect_cyc("bp.E", 4'b0000, 1'b1, 6'h02, 2'd1);
    expect_cyc("bp.F", 4'b0000, 1'b0, 6'h00, 2'd0);
    Pausa = 1'b0;
    expect_cyc("bp.G", 4'b0100, 1'b0, 6'h00, 2'd0);
    expect_cyc("bp.H", 4'b1000, 1'b0, 6'h00, 2'd0);
    expect_cyc("bp.I", 4'b0001, 1'b1, 6'h03, 2'd2);
    expect_cyc("bp.J", 4'b0010, 1'b1, 6'h04, 2'd3);
    expect_cyc("bp.K", 4'b0100, 1'b1, 6'h05, 2'd0);
    expect_cyc("bp.L", 4'b1000, 1'b1, 6'h06, 2'd1);
    expect_cyc("bp.M", 4'b0000, 1'b1, 6'h07, 2'd2);
    expect_cyc("bp.N", 4'b0000, 1'b1, 6'h08, 2'd3);

    do_reset();
    load_all2();
    enable = 1'b1;
    expect_cyc("err.A", 4'b0000, 1'b0, 6'h00, 2'd0);
    expect_cyc("err.B", 4'b0001, 1'b0, 6'h00, 2'd0);
    Fifo_Error = 4'b0010;
    #1;
    check("err.C.flag", 32'(error_out), 32'h0);
    expect_cyc("err.C", 4'b0010, 1'b0, 6'h00, 2'd0);
    Fifo_Error = '0;
    #1;
    check("err.D.flag", 32'(error_out), 32'h1);
    expect_cyc("err.D", 4'b0000, 1'b1, 6'h01, 2'd0);
    expect_cyc("err.E", 4'b0000, 1'b1, 6'h02, 2'd1);
    for (int k = 0; k < 3; k++) begin
      expect_cyc("err.stuck", 4'b0000, 1'b0, 6'h00, 2'd0);
      check("err.sticky", 32'(error_out), 32'h1);
    end
    do_reset();
    #1;
    check("err.cleared", 32'(error_out), 32'h0);

    do_reset();
    load_all2();
    enable = 1'b1;
    expect_cyc("en.A", 4'b0000, 1'b0, 6'h00, 2'd0);
    expect_cyc("en.B", 4'b0001, 1'b0, 6'h00, 2'd0);
    expect_cyc("en.C", 4'b0010, 1'b0, 6'h00, 2'd0);
    enable = 1'b0;
    expect_cyc("en.D", 4'b0100, 1'b1, 6'h01, 2'd0);
    expect_cyc("en.E", 4'b0000, 1'b1, 6'h02, 2'd1);
    expect_cyc("en.F", 4'b0000, 1'b1, 6'h03, 2'd2);
    enable = 1'b1;
    expect_cyc("en.G", 4'b0000, 1'b0, 6'h00, 2'd0);
    expect_cyc("en.H", 4'b1000, 1'b0, 6'h00, 2'd0);
    expect_cyc("en.I", 4'b0001, 1'b0, 6'h00, 2'd0);
    #1;
    check("ar.pop", 32'(pop), 32'(4'b0010));
    check("ar.valid", 32'(valid_out), 32'h1);
    check("ar.data", 32'(data_out), 32'h04);
    check("ar.ch", 32'(ch_out), 32'd3);
    reset_L = 1'b0;
    #1;
    check("ar.pop0", 32'(pop), 32'h0);
    check("ar.valid0", 32'(valid_out), 32'h0);
    check("ar.data0", 32'(data_out), 32'h0);
    check("ar.ch0", 32'(ch_out), 32'h0);
    check("ar.err0", 32'(error_out), 32'h0);
    @(negedge clk);
    reset_L = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
